// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with a valid/ready output stage.
//
// Collects DATA_WIDTH bits, MSB first, into a word. A word begins on a
// valid bit that carries Frame_Start_In and completes on its DATA_WIDTH-th
// valid bit. The completed word is presented on Parallel_Data_Out one edge
// later. If the previous word is still waiting for the consumer, the new
// word is dropped and the sticky Overrun_Out flag is raised.
//
// Ports
//   Clk_In               clock, rising edge
//   Reset_In             synchronous active-high reset
//   Serial_Data_In       serial bit, MSB of each word first
//   Serial_Valid_In      Serial_Data_In is sampled when 1
//   Frame_Start_In       marks the MSB of a word (qualified by Serial_Valid_In)
//   Data_Ready_In        consumer accepts the held word
//   Parallel_Data_Out    last completed word
//   Data_Valid_Out       Parallel_Data_Out holds an unconsumed word
//   Overrun_Out          sticky: a completed word was dropped
//   Bit_Count_Out        bits collected in the current word
//   SIPO_Shift_Register  shift register contents, for debug
module sipo_deserializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          Clk_In,
  input  logic                          Reset_In,
  input  logic                          Serial_Data_In,
  input  logic                          Serial_Valid_In,
  input  logic                          Frame_Start_In,
  input  logic                          Data_Ready_In,
  output logic [DATA_WIDTH-1:0]         Parallel_Data_Out,
  output logic                          Data_Valid_Out,
  output logic                          Overrun_Out,
  output logic [$clog2(DATA_WIDTH)-1:0] Bit_Count_Out,
  output logic [DATA_WIDTH-1:0]         SIPO_Shift_Register
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0] sr_q,    sr_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q,   ovr_d;

  logic                  word_done_c;
  logic                  xfer_c;
  logic [DATA_WIDTH-1:0] shifted_c;

  // Shift register with the incoming bit appended at the LSB.
  assign shifted_c = {sr_q[DATA_WIDTH-2:0], Serial_Data_In};

  // Consumer handshake on the held word.
  assign xfer_c = valid_q & Data_Ready_In;

  // Next-state and output-stage logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    ovr_d       = ovr_q;
    word_done_c = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a framed bit starts a word; unframed valid bits are ignored.
        if (Serial_Valid_In && Frame_Start_In) begin
          sr_d    = shifted_c;
          cnt_d   = CNT_ONE;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (Serial_Valid_In) begin
          if (Frame_Start_In) begin
            // Re-framing drops the partial word; this bit is the new MSB.
            sr_d  = {{(DATA_WIDTH-1){1'b0}}, Serial_Data_In};
            cnt_d = CNT_ONE;
          end else if (cnt_q == CNT_LAST) begin
            sr_d        = shifted_c;
            cnt_d       = '0;
            state_d     = IDLE;
            word_done_c = 1'b1;
          end else begin
            sr_d  = shifted_c;
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (xfer_c) begin
      valid_d = 1'b0;
    end

    // A finished word may replace the held one only if that slot is free
    // or is being consumed on this same edge; otherwise it is lost.
    if (word_done_c) begin
      if (!valid_q || xfer_c) begin
        data_d  = shifted_c;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Parallel_Data_Out   = data_q;
  assign Data_Valid_Out      = valid_q;
  assign Overrun_Out         = ovr_q;
  assign Bit_Count_Out       = cnt_q;
  assign SIPO_Shift_Register = sr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (DATA_WIDTH = 8).
module tb_sipo_deserializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sdata;
  logic         svalid;
  logic         fstart;
  logic         ready;
  logic [W-1:0] pdata;
  logic         dvalid;
  logic         ovr;
  logic [2:0]   cnt;
  logic [W-1:0] sreg;

  int checks = 0;
  int errors = 0;

  sipo_deserializer #(.DATA_WIDTH(W)) dut (
    .Clk_In              (clk),
    .Reset_In            (rst),
    .Serial_Data_In      (sdata),
    .Serial_Valid_In     (svalid),
    .Frame_Start_In      (fstart),
    .Data_Ready_In       (ready),
    .Parallel_Data_Out   (pdata),
    .Data_Valid_Out      (dvalid),
    .Overrun_Out         (ovr),
    .Bit_Count_Out       (cnt),
    .SIPO_Shift_Register (sreg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic d, input logic fs);
    sdata  = d;
    fstart = fs;
    svalid = 1'b1;
    tick();
    svalid = 1'b0;
    fstart = 1'b0;
    sdata  = 1'b0;
  endtask

  // Sends the top n bits of w (MSB first), framing the first, with gap idle edges between bits.
  task automatic send_bits(input logic [W-1:0] w, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_bit(w[W-1-i], i == 0);
      if (i != n - 1) repeat (gap) tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sdata = 1'b0; svalid = 1'b0; fstart = 1'b0; ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_pdata",  32'(pdata),  32'h0);
    chk("rst_dvalid", 32'(dvalid), 32'h0);
    chk("rst_ovr",    32'(ovr),    32'h0);
    chk("rst_cnt",    32'(cnt),    32'h0);
    chk("rst_sreg",   32'(sreg),   32'h0);

    // Unframed valid bits in IDLE are ignored
    svalid = 1'b1; sdata = 1'b1; fstart = 1'b0;
    repeat (3) tick();
    svalid = 1'b0; sdata = 1'b0;
    chk("idle_cnt",  32'(cnt),  32'h0);
    chk("idle_sreg", 32'(sreg), 32'h0);

    // Basic word 0x6D, consumer ready: valid for exactly one cycle
    ready = 1'b1;
    send_bits(8'h6D, 8, 0);
    chk("w6d_pdata",  32'(pdata),  32'h6D);
    chk("w6d_dvalid", 32'(dvalid), 32'h1);
    chk("w6d_cnt",    32'(cnt),    32'h0);
    tick();
    chk("w6d_drop_valid", 32'(dvalid), 32'h0);
    chk("w6d_hold_pdata", 32'(pdata),  32'h6D);

    // Word 0xA1 with 3-cycle gaps; count steps 1..7 then back to 0
    for (int i = 0; i < W; i++) begin
      send_bit(1'(8'hA1 >> (W - 1 - i)), i == 0);
      if (i < W - 1) begin
        chk("gap_cnt", 32'(cnt), 32'(i + 1));
        repeat (3) tick();
        chk("gap_cnt_hold", 32'(cnt), 32'(i + 1));
      end
    end
    chk("wa1_cnt",    32'(cnt),    32'h0);
    chk("wa1_pdata",  32'(pdata),  32'hA1);
    chk("wa1_dvalid", 32'(dvalid), 32'h1);
    tick();

    // Back-to-back frames with no idle edge between them
    send_bits(8'h6D, 8, 0);
    chk("b2b_first", 32'(pdata), 32'h6D);
    send_bits(8'hA1, 8, 0);
    chk("b2b_second", 32'(pdata),  32'hA1);
    chk("b2b_valid",  32'(dvalid), 32'h1);
    chk("b2b_ovr",    32'(ovr),    32'h0);
    tick();

    // Overrun: consumer stalled across two words
    ready = 1'b0;
    send_bits(8'h6D, 8, 0);
    chk("ovr_first_pdata", 32'(pdata), 32'h6D);
    chk("ovr_first_ovr",   32'(ovr),   32'h0);
    send_bits(8'hA1, 8, 1);
    chk("ovr_pdata",  32'(pdata),  32'h6D);
    chk("ovr_flag",   32'(ovr),    32'h1);
    chk("ovr_dvalid", 32'(dvalid), 32'h1);
    ready = 1'b1;
    tick();
    chk("ovr_xfer_dvalid", 32'(dvalid), 32'h0);
    chk("ovr_sticky",      32'(ovr),    32'h1);
    do_reset();
    chk("ovr_cleared", 32'(ovr), 32'h0);

    // Re-frame after 4 bits of 0xFF, then 0x3C
    ready = 1'b0;
    send_bits(8'hFF, 4, 0);
    chk("refr_cnt4",   32'(cnt),    32'h4);
    chk("refr_nvalid", 32'(dvalid), 32'h0);
    send_bits(8'h3C, 8, 0);
    chk("refr_pdata",  32'(pdata),  32'h3C);
    chk("refr_dvalid", 32'(dvalid), 32'h1);
    chk("refr_ovr",    32'(ovr),    32'h0);

    // Reset mid-word and mid-handshake (0x3C still held)
    send_bits(8'hC3, 5, 0);
    chk("mid_cnt5", 32'(cnt), 32'h5);
    rst = 1'b1; ready = 1'b1; svalid = 1'b1; sdata = 1'b1; fstart = 1'b1;
    tick();
    rst = 1'b0; ready = 1'b0; svalid = 1'b0; sdata = 1'b0; fstart = 1'b0;
    chk("mrst_pdata",  32'(pdata),  32'h0);
    chk("mrst_dvalid", 32'(dvalid), 32'h0);
    chk("mrst_ovr",    32'(ovr),    32'h0);
    chk("mrst_cnt",    32'(cnt),    32'h0);
    chk("mrst_sreg",   32'(sreg),   32'h0);
    send_bits(8'h5A, 8, 0);
    chk("post_rst_pdata",  32'(pdata),  32'h5A);
    chk("post_rst_dvalid", 32'(dvalid), 32'h1);

    // Transfer and completion on the same edge
    do_reset();
    ready = 1'b0;
    send_bits(8'h11, 8, 0);
    chk("same_first", 32'(pdata), 32'h11);
    send_bits(8'h22, 7, 0);
    chk("same_wait", 32'(pdata), 32'h11);
    ready = 1'b1;
    send_bit(1'b0, 1'b0);
    chk("same_pdata",  32'(pdata),  32'h22);
    chk("same_dvalid", 32'(dvalid), 32'h1);
    chk("same_ovr",    32'(ovr),    32'h0);
    tick();
    chk("same_drain", 32'(dvalid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
